keypad_scan_ctrl: RTL and testbench

//  Scan controller for the 4x4 vending-machine keypad: drives the active-low column strobe, samples the active-low rows,

---
 rtl/keypad_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with sweep-level debounce and one key_valid strobe per press
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  state_t         r_state;
  logic [3:0]     r_row_s1, r_row_s2;
  logic [DW-1:0]  r_div;
  logic [1:0]     r_col;
  logic [1:0]     r_cnt;
  logic [3:0]     r_code;
  logic [3:0]     r_cand;
  logic [3:0]     r_stable;
  logic [3:0]     r_rel;
  logic [3:0]     r_key_code;
  logic           r_valid, r_held, r_multi;

  logic           w_last, w_sweep_end;
  logic [3:0]     w_pressed;
  logic [1:0]     w_col_cnt, w_row_idx, w_tot;
  logic [2:0]     w_sum;
  logic [3:0]     w_code, w_cand_nxt, w_stable_nxt, w_rel_nxt;

  assign w_last       = r_div == DW'(SCAN_DIV - 1);
  assign w_sweep_end  = w_last && r_col == 2'd3;
  assign w_pressed    = ~r_row_s2;
  assign w_col_cnt    = w_pressed == 4'd0 ? 2'd0 : (w_pressed & (w_pressed - 4'd1)) == 4'd0 ? 2'd1 : 2'd2;
  assign w_row_idx    = w_pressed[3] ? 2'd0 : w_pressed[2] ? 2'd1 : w_pressed[1] ? 2'd2 : 2'd3;
  assign w_sum        = {1'b0, r_cnt} + {1'b0, w_col_cnt};
  assign w_tot        = w_sum >= 3'd2 ? 2'd2 : w_sum[1:0];
  assign w_code       = (r_cnt == 2'd0 && w_col_cnt != 2'd0) ? {r_col, w_row_idx} : r_code;
  assign w_cand_nxt   = w_tot == 2'd1 ? w_code : r_cand;
  assign w_stable_nxt = w_tot != 2'd1 ? 4'd0 : w_code != r_cand ? 4'd1 : r_stable == DB ? DB : r_stable + 4'd1;
  assign w_rel_nxt    = w_tot != 2'd0 ? 4'd0 : r_rel == DB ? DB : r_rel + 4'd1;

  assign shift_col = ~(4'b1000 >> r_col);
  assign key_code  = r_key_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign multi_key = r_multi;

  // two-flop synchronizer for the asynchronous row pins
  always_ff @(posedge clk or negedge reset)
    if (!reset) {r_row_s1, r_row_s2} <= 8'hFF;
    else {r_row_s1, r_row_s2} <= {row, r_row_s1};

  // column timing: SCAN_DIV clocks per column, columns 0..3 in turn
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_div <= '0;
      r_col <= 2'd0;
    end else begin
      r_div <= w_last ? '0 : r_div + 1'b1;
      if (w_last) r_col <= r_col + 2'd1;
    end

  // per-sweep pressed-key count (saturating at 2) and first key code found
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt  <= 2'd0;
      r_code <= 4'd0;
    end else if (w_last) begin
      r_cnt  <= w_sweep_end ? 2'd0 : w_tot;
      r_code <= w_sweep_end ? 4'd0 : w_code;
    end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] r_rep;
  logic          w_rep_adv, w_rep_hit;
  assign w_rep_adv = w_tot == 2'd1 && w_code == r_key_code;
  assign w_rep_hit = w_rep_adv && r_rep + 1'b1 == RW'(REPEAT_SCANS);
`endif

  // debounce FSM evaluated once per sweep end; all outputs registered
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= IDLE;
      r_cand     <= 4'd0;
      r_stable   <= 4'd0;
      r_rel      <= 4'd0;
      r_key_code <= 4'd0;
      r_valid    <= 1'b0;
      r_held     <= 1'b0;
      r_multi    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep      <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (w_sweep_end) begin
        r_multi <= w_tot == 2'd2;
        if (r_state == IDLE) begin
          r_cand   <= w_cand_nxt;
          r_stable <= w_stable_nxt;
          if (w_stable_nxt == DB) begin
            r_key_code <= w_cand_nxt;
            r_valid    <= 1'b1;
            r_held     <= 1'b1;
            r_rel      <= 4'd0;
            r_state    <= HELD;
`ifdef KEYPAD_REPEAT_EN
            r_rep      <= '0;
`endif
          end
        end else begin
          r_rel <= w_rel_nxt;
`ifdef KEYPAD_REPEAT_EN
          r_rep <= (!w_rep_adv || w_rep_hit) ? '0 : r_rep + 1'b1;
          if (w_rep_hit) r_valid <= 1'b1;
`endif
          if (w_rel_nxt == DB) begin
            r_held   <= 1'b0;
            r_stable <= 4'd0;
            r_state  <= IDLE;
          end
        end
      end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed vector table, reset-mid-press sequence and random key sweeps vs a sweep-level model
module tb_keypad_scan_ctrl;
  localparam int D = 3;
  localparam int R = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_PULSES = 2;
`else
  localparam int REP_PULSES = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row, shift_col, key_code;
  logic       key_valid, key_held, multi_key;
  logic [15:0] keys = 16'h0;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  int         m_stable, m_rel, m_rep;
  logic [3:0] m_cand, m_code;
  logic       m_held, m_multi, m_valid;

  typedef struct {
    logic [15:0] keys;
    int          sweeps;
    int          pulses;
    logic [3:0]  code;
    logic        held;
    logic        multi;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl dut (
    .clk(clk), .reset(reset), .row(row), .shift_col(shift_col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  // keypad matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!shift_col[3-c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row[3-r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = 0; m_rel = 0; m_rep = 0;
    m_cand = 4'd0; m_code = 4'd0;
    m_held = 1'b0; m_multi = 1'b0; m_valid = 1'b0;
  endtask

  // reference: what a whole sweep of a constant key set does to the debounced outputs
  task automatic model_sweep(input logic [15:0] k);
    int cnt;
    logic [3:0] code;
    cnt = $countones(k);
    if (cnt > 2) cnt = 2;
    code = 4'd0;
    for (int i = 15; i >= 0; i--) if (k[i]) code = 4'(i);
    m_multi = cnt == 2;
    m_valid = 1'b0;
    if (!m_held) begin
      if (cnt == 1 && code == m_cand) m_stable = m_stable < D ? m_stable + 1 : D;
      else if (cnt == 1) begin m_cand = code; m_stable = 1; end
      else m_stable = 0;
      if (m_stable == D) begin
        m_code = m_cand; m_valid = 1'b1; m_held = 1'b1; m_rel = 0; m_rep = 0;
      end
    end else begin
      m_rel = cnt == 0 ? (m_rel < D ? m_rel + 1 : D) : 0;
      if (REP_PULSES != 0) begin
        if (cnt == 1 && code == m_code) begin
          m_rep++;
          if (m_rep == R) begin m_valid = 1'b1; m_rep = 0; end
        end else m_rep = 0;
      end
      if (m_rel == D) begin m_held = 1'b0; m_stable = 0; end
    end
  endtask

  // one full sweep with the given keys; every clock compared against the model
  task automatic do_sweep(input logic [15:0] k);
    keys = k;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 16) model_sweep(k);
      else m_valid = 1'b0;
      check("cycle", {21'd0, shift_col, key_valid, key_code, key_held, multi_key},
            {21'd0, ~(4'b1000 >> ((i % 16) / 4)), m_valid, m_code, m_held, m_multi});
      if (key_valid) pulses++;
    end
  endtask

  function automatic void add(input logic [15:0] k, input int s, input int p,
                              input logic [3:0] c, input logic h, input logic m);
    vec_t v;
    v.keys = k; v.sweeps = s; v.pulses = p; v.code = c; v.held = h; v.multi = m;
    tv.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] prev, k;
    int kind, hold, a, b;
    add(16'h0000, 10, 0,          4'h0, 1'b0, 1'b0);
    add(16'h0008,  3, 1,          4'h3, 1'b1, 1'b0);
    add(16'h0008, 17, REP_PULSES, 4'h3, 1'b1, 1'b0);
    add(16'h0000,  2, 0,          4'h3, 1'b1, 1'b0);
    add(16'h0000,  1, 0,          4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      add(16'h0008, 1, 0, 4'h3, 1'b0, 1'b0);
      add(16'h0000, 1, 0, 4'h3, 1'b0, 1'b0);
    end
    add(16'h0048,  4, 0,          4'h3, 1'b0, 1'b1);
    add(16'h0040,  3, 1,          4'h6, 1'b1, 1'b0);
    add(16'h0000,  3, 0,          4'h6, 1'b0, 1'b0);
    add(16'h0008,  3, 1,          4'h3, 1'b1, 1'b0);
    add(16'h0200,  3, 0,          4'h3, 1'b1, 1'b0);
    add(16'h0000,  3, 0,          4'h3, 1'b0, 1'b0);

    model_reset();
    #1;
    check("reset_outputs", {25'd0, shift_col, key_valid, key_held, multi_key},
          {25'd0, 4'b0111, 3'b000});
    check("reset_code", {28'd0, key_code}, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;

    foreach (tv[n]) begin
      pulses = 0;
      for (int s = 0; s < tv[n].sweeps; s++) do_sweep(tv[n].keys);
      check($sformatf("vec%0d_pulses", n), pulses, tv[n].pulses);
      check($sformatf("vec%0d_code", n), {28'd0, key_code}, {28'd0, tv[n].code});
      check($sformatf("vec%0d_held", n), {31'd0, key_held}, {31'd0, tv[n].held});
      check($sformatf("vec%0d_multi", n), {31'd0, multi_key}, {31'd0, tv[n].multi});
    end

    do_sweep(16'h0020);
    do_sweep(16'h0020);
    reset = 1'b0;
    #1;
    check("midreset_outputs", {21'd0, shift_col, key_valid, key_code, key_held, multi_key},
          {21'd0, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0});
    model_reset();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    do_sweep(16'h0020);
    do_sweep(16'h0020);
    check("midreset_early", pulses, 0);
    do_sweep(16'h0020);
    check("midreset_pulse", pulses, 1);
    check("midreset_code", {28'd0, key_code}, 32'h5);
    check("midreset_held", {31'd0, key_held}, 32'd1);

    prev = 16'h0020;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      k = kind == 0 ? 16'h0 : kind == 1 ? 16'h1 << a : kind == 2 ? (16'h1 << a) | (16'h1 << b) : prev;
      hold = $urandom_range(1, 5);
      for (int s = 0; s < hold; s++) do_sweep(k);
      prev = k;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
